wb_stage: RTL and testbench

Write-back stage of the five-stage core: the consumer end of the MEM-stage bundle (`mem_stage_if.i`). Latches each MEM result into a MEM/WB register, merges data-RAM read data for loads, and drives the register-file and CSR write ports. Turns MEM-reported exceptions into a one-cycle commit-time exception pulse, and publishes a per-instruction commit trace plus retired-instruction counter. Each valid instruction commits exactly once, even when the stage is held by a stall.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/width_param.sv | 8 +
 rtl/mem_stage_if.sv | 20 ++
 rtl/load_align.sv | 27 ++
 rtl/wb_stage.sv | 97 +++++++++
 tb/tb_wb_stage.sv | 247 ++++++++++++++++++++++++
 6 files changed

// File: rtl/wb_pkg.sv
// Write-back stage types: load opcodes, exception encoding and MEM/WB payload.
package wb_pkg;
  import width_param::*;

  localparam logic [9:0] OP_LDB  = 10'h0A0;
  localparam logic [9:0] OP_LDH  = 10'h0A1;
  localparam logic [9:0] OP_LDW  = 10'h0A2;
  localparam logic [9:0] OP_LDBU = 10'h0A8;
  localparam logic [9:0] OP_LDHU = 10'h0A9;

  localparam logic [DATA_WIDTH-1:0] EXC_NONE = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0]   inst;
    logic                    ram_rd_en;
    logic                    csr_wen;
    logic [CSRNUM_WIDTH-1:0] csr_waddr;
    logic [DATA_WIDTH-1:0]   csr_wdata;
    logic [DATA_WIDTH-1:0]   except_type;
    logic [INST_WIDTH-1:0]   except_pc;
    logic [DATA_WIDTH-1:0]   rw_data;
    logic [REG_WIDTH-1:0]    rw_addr;
    logic                    rw_en;
  } wb_reg_t;
endpackage

// File: rtl/width_param.sv
// Core-wide datapath widths shared by every pipeline stage.
package width_param;
  localparam int ADDR_WIDTH   = 32;
  localparam int INST_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int REG_WIDTH    = 5;
  localparam int CSRNUM_WIDTH = 14;
endpackage

// File: rtl/mem_stage_if.sv
// MEM-stage result bundle; MEM drives the o side, WB consumes the i side.
interface mem_stage_if;
  import width_param::*;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [INST_WIDTH-1:0]   inst;
  logic                    ram_rd_en;
  logic                    csr_wen;
  logic [CSRNUM_WIDTH-1:0] csr_waddr;
  logic [DATA_WIDTH-1:0]   csr_wdata;
  logic [DATA_WIDTH-1:0]   except_type;
  logic [INST_WIDTH-1:0]   except_pc;
  logic [DATA_WIDTH-1:0]   rw_data;
  logic [REG_WIDTH-1:0]    rw_addr;
  logic                    rw_en;

  modport o (output pc, inst, ram_rd_en, csr_wen, csr_waddr, csr_wdata,
                    except_type, except_pc, rw_data, rw_addr, rw_en);
  modport i (input  pc, inst, ram_rd_en, csr_wen, csr_waddr, csr_wdata,
                    except_type, except_pc, rw_data, rw_addr, rw_en);
endinterface

// File: rtl/load_align.sv
// Selects and extends the byte/half/word of a data-RAM read word for a load.
module load_align
  import width_param::*, wb_pkg::*;
(
  input  logic [9:0]            i_op,
  input  logic [1:0]            i_addr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_rdata >> {i_addr, 3'b000});
  assign w_half = 16'(i_rdata >> {i_addr[1], 4'b0000});

  always_comb begin
    o_data = i_rdata;
    case (i_op)
      OP_LDB:  o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      OP_LDBU: o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      OP_LDH:  o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      OP_LDHU: o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      OP_LDW:  o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load merge, RF/CSR write ports,
// commit-time exception pulse, commit trace and retired-instruction counter.
module wb_stage
  import width_param::*, wb_pkg::*;
#(
  parameter int CNT_WIDTH = 64
)(
  input  logic                    clk,
  input  logic                    rst,
  mem_stage_if.i                  mem_i,
  input  logic                    mem_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data,
  output logic                    rf_we,
  output logic [REG_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  output logic                    csr_we,
  output logic [CSRNUM_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0]   csr_wdata,
  output logic                    excp_valid,
  output logic [DATA_WIDTH-1:0]   excp_type,
  output logic [INST_WIDTH-1:0]   excp_pc,
  output logic                    commit_valid,
  output logic [ADDR_WIDTH-1:0]   commit_pc,
  output logic [INST_WIDTH-1:0]   commit_inst,
  output logic [CNT_WIDTH-1:0]    retire_cnt
);
  wb_reg_t               r_reg;
  logic                  r_wb_valid;
  logic                  r_wb_done;
  logic [CNT_WIDTH-1:0]  r_retire_cnt;

  wb_reg_t               w_in;
  logic                  w_live;
  logic                  w_exc;
  logic [DATA_WIDTH-1:0] w_ld_data;

  assign w_in = '{pc:          mem_i.pc,
                  inst:        mem_i.inst,
                  ram_rd_en:   mem_i.ram_rd_en,
                  csr_wen:     mem_i.csr_wen,
                  csr_waddr:   mem_i.csr_waddr,
                  csr_wdata:   mem_i.csr_wdata,
                  except_type: mem_i.except_type,
                  except_pc:   mem_i.except_pc,
                  rw_data:     mem_i.rw_data,
                  rw_addr:     mem_i.rw_addr,
                  rw_en:       mem_i.rw_en};

  // wb_done marks an instruction that already committed while held by a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_done  <= 1'b0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
      r_wb_done  <= 1'b0;
    end else if (stall) begin
      r_wb_done  <= r_wb_done | r_wb_valid;
    end else begin
      r_reg      <= w_in;
      r_wb_valid <= mem_valid;
      r_wb_done  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               r_retire_cnt <= '0;
    else if (commit_valid) r_retire_cnt <= r_retire_cnt + CNT_WIDTH'(1);
  end

  assign w_live       = r_wb_valid & ~r_wb_done;
  assign w_exc        = w_live & (r_reg.except_type != EXC_NONE);
  assign commit_valid = w_live & ~w_exc;

  load_align u_load_align (
    .i_op    (r_reg.inst[31:22]),
    .i_addr  (r_reg.rw_data[1:0]),
    .i_rdata (ram_rd_data),
    .o_data  (w_ld_data)
  );

  assign rf_we        = commit_valid & r_reg.rw_en & (r_reg.rw_addr != '0);
  assign rf_waddr     = r_reg.rw_addr;
  assign rf_wdata     = r_reg.ram_rd_en ? w_ld_data : r_reg.rw_data;
  assign csr_we       = commit_valid & r_reg.csr_wen;
  assign csr_waddr    = r_reg.csr_waddr;
  assign csr_wdata    = r_reg.csr_wdata;
  assign excp_valid   = w_exc;
  assign excp_type    = r_reg.except_type;
  assign excp_pc      = r_reg.except_pc;
  assign commit_pc    = r_reg.pc;
  assign commit_inst  = r_reg.inst;
  assign retire_cnt   = r_retire_cnt;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected WB outputs are queued as each
// instruction is presented and compared in the cycle it occupies WB.
module tb_wb_stage;
  import width_param::*;
  localparam int CW = 64;

  logic clk = 1'b0;
  logic rst, mem_valid, stall, flush;
  logic [DATA_WIDTH-1:0]   ram_rd_data;
  logic                    rf_we, csr_we, excp_valid, commit_valid;
  logic [REG_WIDTH-1:0]    rf_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata, csr_wdata, excp_type;
  logic [CSRNUM_WIDTH-1:0] csr_waddr;
  logic [INST_WIDTH-1:0]   excp_pc, commit_inst;
  logic [ADDR_WIDTH-1:0]   commit_pc;
  logic [CW-1:0]           retire_cnt;

  mem_stage_if mi();

  wb_stage #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mem_i(mi), .mem_valid(mem_valid), .stall(stall),
    .flush(flush), .ram_rd_data(ram_rd_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .excp_valid(excp_valid), .excp_type(excp_type), .excp_pc(excp_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                    rf_we;
    logic [REG_WIDTH-1:0]    wa;
    logic [DATA_WIDTH-1:0]   wd;
    logic                    csr_we;
    logic [CSRNUM_WIDTH-1:0] ca;
    logic [DATA_WIDTH-1:0]   cd;
    logic                    ex;
    logic [DATA_WIDTH-1:0]   et;
    logic [INST_WIDTH-1:0]   ep;
    logic                    cm;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0]   inst;
  } exp_t;

  exp_t    sbq[$];
  string   tagq[$];
  int      n_vec = 0;
  int      n_err = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    mem_valid = 0; stall = 0; flush = 0;
    mi.pc = '0; mi.inst = '0; mi.ram_rd_en = 0; mi.csr_wen = 0;
    mi.csr_waddr = '0; mi.csr_wdata = '0; mi.except_type = '0; mi.except_pc = '0;
    mi.rw_data = '0; mi.rw_addr = '0; mi.rw_en = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [4:0] ra, input logic [31:0] rd, input logic ld);
    clr();
    mem_valid = 1; mi.pc = pc; mi.inst = inst;
    mi.rw_addr = ra; mi.rw_data = rd; mi.rw_en = 1; mi.ram_rd_en = ld;
  endtask

  task automatic expn(input string tag);
    exp_t e;
    e = '{default: '0};
    sbq.push_back(e); tagq.push_back(tag);
  endtask

  // commit pc/inst are the values this bench is presenting on mem_i
  task automatic expc(input string tag, input logic rfw, input logic [4:0] wa,
                      input logic [31:0] wd, input logic cw, input logic [13:0] ca,
                      input logic [31:0] cd);
    exp_t e;
    e = '{default: '0};
    e.rf_we = rfw; e.wa = wa; e.wd = wd; e.csr_we = cw; e.ca = ca; e.cd = cd;
    e.cm = 1; e.pc = mi.pc; e.inst = mi.inst;
    sbq.push_back(e); tagq.push_back(tag);
  endtask

  task automatic expx(input string tag, input logic [31:0] et, input logic [31:0] ep);
    exp_t e;
    e = '{default: '0};
    e.ex = 1; e.et = et; e.ep = ep;
    sbq.push_back(e); tagq.push_back(tag);
  endtask

  task automatic step(input logic [31:0] ram);
    exp_t e;
    string t;
    @(posedge clk);
    #1 ram_rd_data = ram;
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk("sb_underflow", 64'(sbq.size()), 64'd1);
    end else begin
      e = sbq.pop_front(); t = tagq.pop_front();
      chk({t, ".rf_we"}, 64'(rf_we), 64'(e.rf_we));
      if (e.rf_we) begin
        chk({t, ".rf_waddr"}, 64'(rf_waddr), 64'(e.wa));
        chk({t, ".rf_wdata"}, 64'(rf_wdata), 64'(e.wd));
      end
      chk({t, ".csr_we"}, 64'(csr_we), 64'(e.csr_we));
      if (e.csr_we) begin
        chk({t, ".csr_waddr"}, 64'(csr_waddr), 64'(e.ca));
        chk({t, ".csr_wdata"}, 64'(csr_wdata), 64'(e.cd));
      end
      chk({t, ".excp_valid"}, 64'(excp_valid), 64'(e.ex));
      if (e.ex) begin
        chk({t, ".excp_type"}, 64'(excp_type), 64'(e.et));
        chk({t, ".excp_pc"}, 64'(excp_pc), 64'(e.ep));
      end
      chk({t, ".commit_valid"}, 64'(commit_valid), 64'(e.cm));
      if (e.cm) begin
        chk({t, ".commit_pc"}, 64'(commit_pc), 64'(e.pc));
        chk({t, ".commit_inst"}, 64'(commit_inst), 64'(e.inst));
      end
      chk({t, ".retire_cnt"}, retire_cnt, exp_cnt);
      if (e.cm) exp_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    ram_rd_data = '0;
    // reset wins over a valid instruction on the input
    instr(32'h1C00_0FFC, 32'h0280_0000, 5'd4, 32'hFFFF_FFFF, 1'b0);
    rst = 1;
    expn("reset");
    step(32'h0);
    chk("rst.rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst.rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst.csr_waddr", 64'(csr_waddr), 64'd0);
    chk("rst.csr_wdata", 64'(csr_wdata), 64'd0);
    chk("rst.excp_type", 64'(excp_type), 64'd0);
    chk("rst.excp_pc", 64'(excp_pc), 64'd0);
    chk("rst.commit_pc", 64'(commit_pc), 64'd0);
    chk("rst.commit_inst", 64'(commit_inst), 64'd0);
    rst = 0;

    instr(32'h1C00_0000, 32'h0280_0000, 5'd5, 32'h0000_1234, 1'b0);
    expc("alu", 1, 5'd5, 32'h0000_1234, 0, '0, '0);
    step(32'h0);

    // back-to-back loads, one per cycle
    instr(32'h1C00_0004, {10'h0A0, 22'h0}, 5'd7, 32'h0000_1003, 1'b1);
    expc("ld.b", 1, 5'd7, 32'hFFFF_FF80, 0, '0, '0);
    step(32'h80FF_0000);
    instr(32'h1C00_0008, {10'h0A9, 22'h0}, 5'd8, 32'h0000_1002, 1'b1);
    expc("ld.hu", 1, 5'd8, 32'h0000_80FF, 0, '0, '0);
    step(32'h80FF_0000);
    instr(32'h1C00_000C, {10'h0A1, 22'h0}, 5'd9, 32'h0000_1002, 1'b1);
    expc("ld.h", 1, 5'd9, 32'hFFFF_80FF, 0, '0, '0);
    step(32'h80FF_0000);
    instr(32'h1C00_0010, {10'h0A8, 22'h0}, 5'd10, 32'h0000_1001, 1'b1);
    expc("ld.bu", 1, 5'd10, 32'h0000_0056, 0, '0, '0);
    step(32'h1234_5678);
    instr(32'h1C00_0014, {10'h0A2, 22'h0}, 5'd11, 32'h0000_1000, 1'b1);
    expc("ld.w", 1, 5'd11, 32'h80FF_0000, 0, '0, '0);
    step(32'h80FF_0000);
    instr(32'h1C00_0018, {10'h3FF, 22'h0}, 5'd12, 32'h0000_1001, 1'b1);
    expc("ld.other", 1, 5'd12, 32'hCAFE_F00D, 0, '0, '0);
    step(32'hCAFE_F00D);

    // exception: one-cycle pulse, writes suppressed, counter held at 7
    instr(32'h1C00_0010, 32'h0280_0000, 5'd6, 32'h0000_5555, 1'b0);
    mi.except_type = 32'h4; mi.except_pc = 32'h1C00_0010;
    mi.csr_wen = 1; mi.csr_waddr = 14'h5; mi.csr_wdata = 32'h1;
    expx("excp", 32'h4, 32'h1C00_0010);
    step(32'h0);
    clr();
    expn("excp.after");
    step(32'h0);

    // reset asserted while an instruction is in WB and retire_cnt is 7
    instr(32'h1C00_0020, 32'h0280_0000, 5'd1, 32'h0000_0077, 1'b0);
    expc("pre_rst", 1, 5'd1, 32'h0000_0077, 0, '0, '0);
    step(32'h0);
    rst = 1; stall = 1; mem_valid = 1;
    exp_cnt = '0;
    expn("rst_mid");
    step(32'h0);
    rst = 0; clr();
    expn("rst_after");
    step(32'h0);

    // stall held for three cycles commits once
    instr(32'h1C00_0030, 32'h0280_0000, 5'd9, 32'h0000_00AA, 1'b0);
    expc("stall.first", 1, 5'd9, 32'h0000_00AA, 0, '0, '0);
    step(32'h0);
    instr(32'h1C00_0034, 32'h0280_0000, 5'd10, 32'h0000_00BB, 1'b0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      expn("stall.hold");
      step(32'h0);
    end
    clr();
    expn("stall.release");
    step(32'h0);

    // flush with stall empties WB; the resident instruction is unaffected
    instr(32'h1C00_0040, 32'h0280_0000, 5'd11, 32'h0000_00CC, 1'b0);
    expc("flush.resident", 1, 5'd11, 32'h0000_00CC, 0, '0, '0);
    step(32'h0);
    instr(32'h1C00_0044, 32'h0280_0000, 5'd12, 32'h0000_00DD, 1'b0);
    stall = 1; flush = 1;
    #1 chk("flush.no_comb", 64'(commit_valid), 64'd1);
    expn("flush+stall");
    step(32'h0);
    instr(32'h1C00_0048, 32'h0280_0000, 5'd13, 32'h0000_00EE, 1'b0);
    flush = 1;
    expn("flush");
    step(32'h0);

    // write to r0 retires without a register-file write
    instr(32'h1C00_0050, 32'h0280_0000, 5'd0, 32'h0000_0099, 1'b0);
    expc("r0", 0, 5'd0, 32'h0, 0, '0, '0);
    step(32'h0);

    instr(32'h1C00_0054, 32'h0400_0000, 5'd3, 32'h0000_0055, 1'b0);
    mi.csr_wen = 1; mi.csr_waddr = 14'h180; mi.csr_wdata = 32'hDEAD_BEEF;
    expc("csr", 1, 5'd3, 32'h0000_0055, 1, 14'h180, 32'hDEAD_BEEF);
    step(32'h0);
    clr();
    expn("idle");
    step(32'h0);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
